// File: rtl/acc_src_pkg.sv
// Shared constants and helpers for the accumulator source selector.
// Source indices match the select encoding used by the datapath controller.
package acc_src_pkg;

    localparam int NB_DATA_DEF  = 16;

    localparam int SRC_DATA     = 0;
    localparam int SRC_SIGNAL   = 1;
    localparam int SRC_RES_ARIT = 2;

    // Bit offset of source k inside a packed bus of nb-bit sources.
    function automatic int src_lsb(input int k, input int nb);
        return k * nb;
    endfunction

endpackage

// File: rtl/acc_src_mux.sv
// Combinational N_SRC:1 source selector with an out-of-range select flag.
module acc_src_mux
    import acc_src_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int N_SRC   = 3,
    parameter int NB_SEL  = 2
) (
    input  logic [NB_SEL-1:0]        sel,
    input  logic [N_SRC*NB_DATA-1:0] src,
    output logic [NB_DATA-1:0]       data,
    output logic                     out_of_range
);

    always_comb begin
        // NOTE: default first so no select value leaves data unassigned and infers a latch.
        data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (int'(sel) == k) begin
                data = src[src_lsb(k, NB_DATA) +: NB_DATA];
            end
        end
    end

    assign out_of_range = (int'(sel) >= N_SRC);

endmodule

// File: rtl/acc_src_reg.sv
// Registered accumulator fed from a selectable source, with an optional
// capture stage, zero/negative flags, write pulse and sticky select error.
module acc_src_reg
    import acc_src_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int N_SRC   = 3,
    parameter int NB_SEL  = 2,
    parameter int PIPE    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NB_SEL-1:0]        i_sel,
    input  logic [N_SRC*NB_DATA-1:0] i_src,
    input  logic                     i_wr_acc,
    input  logic                     i_clr_err,
    output logic [NB_DATA-1:0]       o_acc,
    output logic                     o_acc_valid,
    output logic                     o_zero,
    output logic                     o_neg,
    output logic                     o_sel_err
);

    logic [NB_DATA-1:0] mux_data;
    logic               sel_oor;
    logic               wr_legal;
    logic               wr_illegal;

    acc_src_mux #(
        .NB_DATA (NB_DATA),
        .N_SRC   (N_SRC),
        .NB_SEL  (NB_SEL)
    ) u_mux (
        .sel          (i_sel),
        .src          (i_src),
        .data         (mux_data),
        .out_of_range (sel_oor)
    );

    assign wr_legal   = i_wr_acc & ~sel_oor;
    assign wr_illegal = i_wr_acc &  sel_oor;

    // Set has priority over clear so a simultaneous bad write is never lost.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
        if (i_reset) begin
            o_sel_err <= 1'b0;
        end else if (wr_illegal) begin
            o_sel_err <= 1'b1;
        end else if (i_clr_err) begin
            o_sel_err <= 1'b0;
        end
    end

    generate
        if (PIPE == 0) begin : g_direct
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    o_acc       <= '0;
                    o_acc_valid <= 1'b0;
                end else begin
                    o_acc_valid <= wr_legal;
                    if (wr_legal) begin
                        o_acc <= mux_data;
                    end
                end
            end
        end else begin : g_pipe
            logic [NB_DATA-1:0] stage_data;
            logic               stage_valid;

            // Reset clears stage_valid, so a write caught in flight never reaches ACC.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    stage_data  <= '0;
                    stage_valid <= 1'b0;
                    o_acc       <= '0;
                    o_acc_valid <= 1'b0;
                end else begin
                    stage_valid <= wr_legal;
                    if (wr_legal) begin
                        stage_data <= mux_data;
                    end
                    o_acc_valid <= stage_valid;
                    if (stage_valid) begin
                        o_acc <= stage_data;
                    end
                end
            end
        end
    endgenerate

    assign o_zero = (o_acc == '0);
    assign o_neg  = o_acc[NB_DATA-1];

endmodule

// File: tb/tb_acc_src_reg.sv
// Directed bench for acc_src_reg: one direct-write and one pipelined instance
// share stimulus; status words pack {acc, valid, zero, neg, err}.
module tb_acc_src_reg;

    localparam int NB   = 16;
    localparam int NS   = 3;
    localparam int NSEL = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSEL-1:0] sel;
    logic [NS*NB-1:0] src;
    logic            wr;
    logic            clr;

    logic [NB-1:0] acc0, acc1;
    logic          v0, z0, n0, e0;
    logic          v1, z1, n1, e1;
    logic [19:0]   st0, st1;
    logic [19:0]   exp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    acc_src_reg #(.NB_DATA(NB), .N_SRC(NS), .NB_SEL(NSEL), .PIPE(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_sel(sel), .i_src(src), .i_wr_acc(wr),
        .i_clr_err(clr), .o_acc(acc0), .o_acc_valid(v0), .o_zero(z0),
        .o_neg(n0), .o_sel_err(e0)
    );

    acc_src_reg #(.NB_DATA(NB), .N_SRC(NS), .NB_SEL(NSEL), .PIPE(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_sel(sel), .i_src(src), .i_wr_acc(wr),
        .i_clr_err(clr), .o_acc(acc1), .o_acc_valid(v1), .o_zero(z1),
        .o_neg(n1), .o_sel_err(e1)
    );

    assign st0 = {acc0, v0, z0, n0, e0};
    assign st1 = {acc1, v1, z1, n1, e1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; clr = 1'b0; sel = '0; src = '0;
        #12;
        exp = {16'h0000, 4'b0100};
        total++; if (st0 !== exp) begin bad++; $display("FAIL reset_p0: got %h want %h", st0, exp); end
        total++; if (st1 !== exp) begin bad++; $display("FAIL reset_p1: got %h want %h", st1, exp); end
        @(posedge clk); #1;
        rst = 1'b0;

        src = {16'h0000, 16'h001F, 16'hF800};
        sel = 2'd0; wr = 1'b1;
        tick();
        wr = 1'b0;
        exp = {16'hF800, 4'b1010};
        total++; if (st0 !== exp) begin bad++; $display("FAIL pre_async_reset: got %h want %h", st0, exp); end
        #2 rst = 1'b1;
        #1;
        exp = {16'h0000, 4'b0100};
        total++; if (st0 !== exp) begin bad++; $display("FAIL async_reset_p0: got %h want %h", st0, exp); end
        total++; if (st1 !== exp) begin bad++; $display("FAIL async_reset_p1: got %h want %h", st1, exp); end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_direct();
        src = {16'h0000, 16'h001F, 16'hF800};

        sel = 2'd0; wr = 1'b1; tick(); wr = 1'b0;
        exp = {16'hF800, 4'b1010};
        total++; if (st0 !== exp) begin bad++; $display("FAIL direct_sel0: got %h want %h", st0, exp); end
        tick();
        exp = {16'hF800, 4'b0010};
        total++; if (st0 !== exp) begin bad++; $display("FAIL direct_sel0_pulse_end: got %h want %h", st0, exp); end

        sel = 2'd1; wr = 1'b1; tick(); wr = 1'b0;
        exp = {16'h001F, 4'b1000};
        total++; if (st0 !== exp) begin bad++; $display("FAIL direct_sel1: got %h want %h", st0, exp); end
        tick();
        exp = {16'h001F, 4'b0000};
        total++; if (st0 !== exp) begin bad++; $display("FAIL direct_sel1_pulse_end: got %h want %h", st0, exp); end

        sel = 2'd2; wr = 1'b1; tick(); wr = 1'b0;
        exp = {16'h0000, 4'b1100};
        total++; if (st0 !== exp) begin bad++; $display("FAIL direct_sel2: got %h want %h", st0, exp); end
        tick();
        exp = {16'h0000, 4'b0100};
        total++; if (st0 !== exp) begin bad++; $display("FAIL direct_sel2_pulse_end: got %h want %h", st0, exp); end
    endtask

    task automatic test_back_to_back();
        src = {16'h0000, 16'h001F, 16'hF800};
        sel = 2'd0; wr = 1'b1; tick();
        exp = {16'h0000, 4'b0100};
        total++; if (st1 !== exp) begin bad++; $display("FAIL pipe_t0: got %h want %h", st1, exp); end
        exp = {16'hF800, 4'b1010};
        total++; if (st0 !== exp) begin bad++; $display("FAIL pipe_t0_direct: got %h want %h", st0, exp); end

        sel = 2'd1; tick();
        exp = {16'hF800, 4'b1010};
        total++; if (st1 !== exp) begin bad++; $display("FAIL pipe_t1: got %h want %h", st1, exp); end

        sel = 2'd2; tick();
        wr = 1'b0;
        exp = {16'h001F, 4'b1000};
        total++; if (st1 !== exp) begin bad++; $display("FAIL pipe_t2: got %h want %h", st1, exp); end

        tick();
        exp = {16'h0000, 4'b1100};
        total++; if (st1 !== exp) begin bad++; $display("FAIL pipe_t3: got %h want %h", st1, exp); end

        tick();
        exp = {16'h0000, 4'b0100};
        total++; if (st1 !== exp) begin bad++; $display("FAIL pipe_t4: got %h want %h", st1, exp); end
    endtask

    task automatic test_illegal();
        src = {16'h0000, 16'h001F, 16'hF800};
        sel = 2'd1; wr = 1'b1; tick();
        wr = 1'b0; tick();

        sel = 2'd3; wr = 1'b1; tick();
        wr = 1'b0;
        exp = {16'h001F, 4'b0001};
        total++; if (st0 !== exp) begin bad++; $display("FAIL illegal_p0: got %h want %h", st0, exp); end
        total++; if (st1 !== exp) begin bad++; $display("FAIL illegal_p1: got %h want %h", st1, exp); end
        tick();
        total++; if (st1 !== exp) begin bad++; $display("FAIL illegal_p1_no_capture: got %h want %h", st1, exp); end

        tick(); tick(); tick();
        total++; if (st0 !== exp) begin bad++; $display("FAIL illegal_sticky: got %h want %h", st0, exp); end

        clr = 1'b1; sel = 2'd3; wr = 1'b1; tick();
        wr = 1'b0;
        total++; if (st0 !== exp) begin bad++; $display("FAIL clr_vs_set: got %h want %h", st0, exp); end

        tick();
        clr = 1'b0;
        exp = {16'h001F, 4'b0000};
        total++; if (st0 !== exp) begin bad++; $display("FAIL clr_err: got %h want %h", st0, exp); end
    endtask

    task automatic test_hold();
        wr = 1'b0;
        exp = {16'h001F, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            sel = NSEL'(i % 4);
            src = {16'(i * 16'h1111), 16'(16'h8000 | i), 16'(~i)};
            tick();
            total++; if (st0 !== exp) begin bad++; $display("FAIL hold_p0 cycle %0d: got %h want %h", i, st0, exp); end
            total++; if (st1 !== exp) begin bad++; $display("FAIL hold_p1 cycle %0d: got %h want %h", i, st1, exp); end
        end
    endtask

    task automatic test_reset_mid_pipe();
        src = {16'h0000, 16'h001F, 16'hF800};
        sel = 2'd0; wr = 1'b1; tick();
        wr = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        exp = {16'h0000, 4'b0100};
        tick();
        total++; if (st1 !== exp) begin bad++; $display("FAIL mid_pipe_reset_t1: got %h want %h", st1, exp); end
        tick();
        total++; if (st1 !== exp) begin bad++; $display("FAIL mid_pipe_reset_t2: got %h want %h", st1, exp); end
        total++; if (st0 !== exp) begin bad++; $display("FAIL mid_pipe_reset_p0: got %h want %h", st0, exp); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_back_to_back();
        test_illegal();
        test_hold();
        test_reset_mid_pipe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
